// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and helpers for the bit-serial subtractor
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must hold 0..WIDTH-1 and never collapse to zero bits.
    function automatic int count_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full subtractor
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, start/done handshake
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sa, sb, sd, sd_next;
    logic             br, d, br_n;
    logic             accept, last;

    full_subtractor u_fs (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (br),
        .d    (d),
        .bout (br_n)
    );

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (state == RUN) && (count == LAST);
    // Shift form stays legal when WIDTH is 1 (no empty part-select).
    assign sd_next = (sd >> 1) | (WIDTH'(d) << (WIDTH - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    state_n = start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            sa    <= '0;
            sb    <= '0;
            sd    <= '0;
            br    <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                sa    <= a;
                sb    <= b;
                br    <= bin;
                count <= '0;
            end else if (state == RUN) begin
                sa <= sa >> 1;
                sb <= sb >> 1;
                sd <= sd_next;
                br <= br_n;
                if (last) begin
                    diff <= sd_next;
                    bout <= br_n;
                end else begin
                    count <= count + CW'(1);
                end
            end
        end
    end

endmodule
